// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the fetch front end's memory, redirect and decode
// signals.
//   master : fetch_queue side (drives im_pc, dec_*, halted, count)
//   slave  : environment side (imem, branch unit, decode)
interface fetch_queue_if #(
  parameter int DEPTH = 4
) ();
  logic [31:0]            im_pc;
  logic [31:0]            im_instr;
  logic                   im_stop;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   dec_valid;
  logic                   dec_ready;
  logic [31:0]            dec_instr;
  logic [31:0]            dec_pc;
  logic                   halted;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output im_pc, dec_valid, dec_instr, dec_pc, halted, count,
    input  im_instr, im_stop, redirect_valid, redirect_pc, dec_ready
  );
  modport slave (
    input  im_pc, dec_valid, dec_instr, dec_pc, halted, count,
    output im_instr, im_stop, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: owns the PC, drives a 1-cycle registered instruction memory,
// and buffers returned words in a DEPTH-entry FIFO for decode.
//   clk  : clock, posedge
//   rst  : asynchronous active-high reset
//   bus  : fetch_queue_if.master
//          im_pc/im_instr/im_stop      - instruction memory
//          redirect_valid/redirect_pc  - branch redirect, flushes everything
//          dec_valid/ready/instr/pc    - FIFO head to decode
//          halted, count               - status
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]            r_pc;
  logic [31:0]            r_inflight_pc;
  logic                   r_inflight;
  logic                   r_halted;
  logic [CW-1:0]          r_count;
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [DEPTH-1:0][31:0] r_fpc;
  logic [DEPTH-1:0][31:0] r_finstr;

  logic w_in_range;
  logic w_credit;
  logic w_stop_cap;
  logic w_issue;
  logic w_push;
  logic w_pop;

  assign w_in_range = r_pc < 32'(MEM_BYTES);
  // Credit counts the in-flight word, so a push can never meet a full FIFO.
  assign w_credit   = ({1'b0, r_count} + {{CW{1'b0}}, r_inflight}) < (CW+1)'(DEPTH);
  assign w_stop_cap = r_inflight && bus.im_stop;
  // No new issue on the cycle the stop word is captured: the PC stays parked
  // just past the stop address instead of running one word further.
  assign w_issue    = !r_halted && !bus.redirect_valid && w_credit && w_in_range && !w_stop_cap;
  assign w_push     = r_inflight && !bus.im_stop && !bus.redirect_valid;
  assign w_pop      = (r_count != '0) && bus.dec_ready && !bus.redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_halted      <= 1'b0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_fpc         <= '0;
      r_finstr      <= '0;
    end else if (bus.redirect_valid) begin
      // Flush: the in-flight word and all buffered entries are dropped.
      r_pc       <= bus.redirect_pc;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + 32'd4;
      end
      if (w_stop_cap || (!r_halted && !w_in_range))
        r_halted <= 1'b1;
      if (w_push) begin
        r_fpc[r_wptr]    <= r_inflight_pc;
        r_finstr[r_wptr] <= bus.im_instr;
        r_wptr           <= r_wptr + AW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.im_pc     = r_pc;
  assign bus.dec_valid = (r_count != '0);
  assign bus.dec_instr = r_finstr[r_rptr];
  assign bus.dec_pc    = r_fpc[r_rptr];
  assign bus.halted    = r_halted;
  assign bus.count     = r_count;
endmodule
